fp_add_seq: RTL and testbench
=============================

Name: fp_add_seq

Overview:
- Multi-cycle sequencer for the floating-point add/subtract datapath.
- Accepts one IEEE-754-style operand pair over a valid/ready handshake. It then steps the operation through align, add and normalize states on successive clocks and holds the packed result and ALUFlags until the consumer accepts them.
- Sits between the ALU issue logic and the writeback/flags path, replacing the single-cycle combinational adder on the FP path.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width; word width = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept; high only in IDLE.
- srcA  in  1+EXP_W+MAN_W  operand A.
- srcB  in  1+EXP_W+MAN_W  operand B.
- sub  in  1  1: compute A-B (B sign inverted at capture); 0: A+B.
- out_valid  out  1  result and flags valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  1+EXP_W+MAN_W  packed sum.
- ALUFlags  out  4  {N,Z,C,V}.

Behaviour:
- Reset (reset low, async):
  - state=IDLE, in_ready=1, out_valid=0, result=0, ALUFlags=0.
  - An operation in flight is discarded with no output.
- States: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_valid & in_ready at edge k registers the operands; state=ALIGN at k+1.
  - Exponent field 0 is treated as zero (hidden bit 0, no denormals).
- ALIGN (1 cycle):
  - Order operands by magnitude {exp,man}; the larger becomes max.
  - Right-shift the smaller 1.MAN_W mantissa by the exponent difference. Difference > MAN_W+1 gives 0.
  - Result exponent = max exponent.
  - Result sign = sign of max. Equal magnitude with opposite effective signs gives sign +.
- ADD (1 cycle):
  - Same effective signs: MAN_W+2-bit sum.
  - Different effective signs: max minus min, never negative.
- NORM:
  - Zero difference: go to DONE with result=+0.
  - Carry bit set: shift right 1, exponent+1, C=1, then DONE.
  - Hidden bit set: DONE.
  - Otherwise: shift left 1 and exponent-1 per cycle until the hidden bit is set. Maximum MAN_W extra cycles.
  - If the exponent reaches 0 while shifting, flush to signed zero.
- Rounding: truncation only; shifted-out bits are dropped.
- Overflow: exponent increment reaching all-ones gives result = sign, exponent all-ones, mantissa 0, V=1.
- Flags: N = result sign, Z = result magnitude zero, C = carry normalization occurred, V = overflow.
- Latency: out_valid rises at k+4 for no-shift cases, k+4+n with n left shifts; maximum k+4+MAN_W.
- DONE:
  - result and ALUFlags stay stable while out_valid=1.
  - out_ready at an edge returns to IDLE; out_valid=0 next cycle.
  - No new input is accepted in the same cycle, since in_ready=0 in DONE.
  - Back-to-back throughput is one operation per (latency+1) cycles.
- in_valid asserted outside IDLE is ignored (not captured). srcA/srcB/sub are sampled only at the accept edge.
- result/ALUFlags update only on entry to DONE; they hold their last values in IDLE.

Test Plan:
- 0x3F800000 + 0x3F800000, out_ready=1 → out_valid 4 cycles after accept, result=0x40000000, flags N0 Z0 C1 V0.
- 0x3FC00000 + 0x3E800000 → result=0x3FE00000 (1.75), C=0, latency 4.
- 0x3F800000 with sub=1 against 0x3F800000 → result=0x00000000, Z=1, N=0. Then 0x3F800000 - 0x3F7FFFFF → 0x34000000 (2^-23), latency 4+23, N=0.
- 0x4B800000 + 0x3F800000 (exponent difference 24) → result=0x4B800000 (truncated). Also 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, V=1.
- Backpressure: hold out_ready=0 for 10 cycles → result/flags stable, in_ready=0, extra in_valid pulses not captured. out_ready=1 → IDLE next cycle.
- Assert reset low during NORM of a long subtract → in_ready=1, out_valid=0, result=0 immediately. Next operation completes correctly after reset release.

Source files
------------

// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point add/subtract sequencer.
// Accepts one operand pair over valid/ready, then walks it through ALIGN,
// ADD and NORM states (one left shift per NORM cycle). It holds the packed
// result and {N,Z,C,V} flags in DONE until the consumer takes them.
// Rounding is truncation. An exponent field of zero means the value zero.
module fp_add_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     srcA,
    input  logic [EXP_W+MAN_W:0]     srcB,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               ALUFlags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int HID_W = MAN_W + 1;
    localparam int SUM_W = MAN_W + 2;

    localparam logic [EXP_W-1:0] EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] EXP_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    // Exponents at or above this overflow when incremented by a carry.
    localparam logic [EXP_W-1:0] EXP_OVF   = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W:0]   MAX_SHIFT = (EXP_W+1)'(MAN_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_r, state_next_s;
    logic [W-1:0]         op_a_r, op_b_r;
    logic                 sign_r, eff_sub_r;
    logic [EXP_W-1:0]     exp_r;
    logic [HID_W-1:0]     man_max_r, man_min_r;
    logic [SUM_W-1:0]     sum_r;
    logic [W-1:0]         result_r;
    logic [3:0]           flags_r;
    logic                 in_ready_r, out_valid_r;

    // Alignment datapath signals
    logic [EXP_W-1:0]     a_exp_s, b_exp_s, max_exp_s, min_exp_s, diff_s;
    logic [HID_W-1:0]     a_man_s, b_man_s, max_man_s, min_man_s, min_al_s;
    logic                 a_ge_b_s, a_eq_b_s, max_sign_s, sign_s, eff_sub_s;
    logic [SUM_W-1:0]     sum_s;

    // Normalization decision signals
    logic                 norm_fin_s;
    logic [W-1:0]         norm_res_s;
    logic [3:0]           norm_flg_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign ALUFlags  = flags_r;

    // Order captured operands by magnitude and align the smaller mantissa.
    always_comb begin
        a_exp_s  = op_a_r[W-2:MAN_W];
        b_exp_s  = op_b_r[W-2:MAN_W];
        a_man_s  = (a_exp_s != EXP_ZERO) ? {1'b1, op_a_r[MAN_W-1:0]} : {HID_W{1'b0}};
        b_man_s  = (b_exp_s != EXP_ZERO) ? {1'b1, op_b_r[MAN_W-1:0]} : {HID_W{1'b0}};
        a_ge_b_s = ({a_exp_s, a_man_s} >= {b_exp_s, b_man_s});
        a_eq_b_s = ({a_exp_s, a_man_s} == {b_exp_s, b_man_s});
        if (a_ge_b_s) begin
            max_exp_s  = a_exp_s;
            max_man_s  = a_man_s;
            max_sign_s = op_a_r[W-1];
            min_exp_s  = b_exp_s;
            min_man_s  = b_man_s;
        end else begin
            max_exp_s  = b_exp_s;
            max_man_s  = b_man_s;
            max_sign_s = op_b_r[W-1];
            min_exp_s  = a_exp_s;
            min_man_s  = a_man_s;
        end
        diff_s = max_exp_s - min_exp_s;
        if ({1'b0, diff_s} > MAX_SHIFT) begin
            min_al_s = {HID_W{1'b0}};
        end else begin
            min_al_s = min_man_s >> diff_s;
        end
        eff_sub_s = op_a_r[W-1] ^ op_b_r[W-1];
        // Exact cancellation always produces +0.
        if (eff_sub_s && a_eq_b_s) begin
            sign_s = 1'b0;
        end else begin
            sign_s = max_sign_s;
        end
    end

    // Mantissa add or magnitude subtract (max >= min, so never negative).
    always_comb begin
        if (eff_sub_r) begin
            sum_s = {1'b0, man_max_r} - {1'b0, man_min_r};
        end else begin
            sum_s = {1'b0, man_max_r} + {1'b0, man_min_r};
        end
    end

    // Decide whether this NORM cycle finishes and what it produces.
    always_comb begin
        norm_fin_s = 1'b0;
        norm_res_s = result_r;
        norm_flg_s = flags_r;
        if (sum_r == {SUM_W{1'b0}}) begin
            norm_fin_s = 1'b1;
            norm_res_s = {W{1'b0}};
            norm_flg_s = 4'b0100;
        end else if (sum_r[SUM_W-1]) begin
            norm_fin_s = 1'b1;
            if (exp_r >= EXP_OVF) begin
                norm_res_s = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
                norm_flg_s = {sign_r, 1'b0, 1'b1, 1'b1};
            end else begin
                norm_res_s = {sign_r, exp_r + EXP_ONE, sum_r[MAN_W:1]};
                norm_flg_s = {sign_r, 1'b0, 1'b1, 1'b0};
            end
        end else if (exp_r == EXP_ZERO) begin
            // Left shifts ran the exponent down to zero: flush to signed zero.
            norm_fin_s = 1'b1;
            norm_res_s = {sign_r, {(W-1){1'b0}}};
            norm_flg_s = {sign_r, 1'b1, 1'b0, 1'b0};
        end else if (sum_r[MAN_W]) begin
            norm_fin_s = 1'b1;
            norm_res_s = {sign_r, exp_r, sum_r[MAN_W-1:0]};
            norm_flg_s = {sign_r, 1'b0, 1'b0, 1'b0};
        end else begin
            norm_fin_s = 1'b0;
        end
    end

    // Next-state logic of the sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_next_s = S_ALIGN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ALIGN: state_next_s = S_ADD;
            S_ADD:   state_next_s = S_NORM;
            S_NORM: begin
                if (norm_fin_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_NORM;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == S_IDLE);
            out_valid_r <= (state_next_s == S_DONE);
        end
    end

    // Operand capture and per-state datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a_r    <= {W{1'b0}};
            op_b_r    <= {W{1'b0}};
            sign_r    <= 1'b0;
            eff_sub_r <= 1'b0;
            exp_r     <= {EXP_W{1'b0}};
            man_max_r <= {HID_W{1'b0}};
            man_min_r <= {HID_W{1'b0}};
            sum_r     <= {SUM_W{1'b0}};
            result_r  <= {W{1'b0}};
            flags_r   <= 4'b0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        op_a_r <= srcA;
                        op_b_r <= {srcB[W-1] ^ sub, srcB[W-2:0]};
                    end
                end
                S_ALIGN: begin
                    sign_r    <= sign_s;
                    eff_sub_r <= eff_sub_s;
                    exp_r     <= max_exp_s;
                    man_max_r <= max_man_s;
                    man_min_r <= min_al_s;
                end
                S_ADD: begin
                    sum_r <= sum_s;
                end
                S_NORM: begin
                    if (norm_fin_s) begin
                        result_r <= norm_res_s;
                        flags_r  <= norm_flg_s;
                    end else begin
                        sum_r <= sum_r << 1'b1;
                        exp_r <= exp_r - EXP_ONE;
                    end
                end
                S_DONE: begin
                    sum_r <= sum_r;
                end
                default: begin
                    sum_r <= sum_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed vectors, randomized
// operations against a value-level reference model, backpressure,
// back-to-back throughput and mid-operation reset.
module tb_fp_add_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] srcA, srcB;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  ALUFlags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_add_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .srcA(srcA), .srcB(srcB), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ALUFlags(ALUFlags)
    );

    // Reference: real-valued rules on integer mantissas, truncating alignment.
    function automatic void ref_add(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] res, output logic [3:0] flg, output int nsh);
        int ea, eb, ex, en, d, e;
        longint ma, mb, mx, mn, sm;
        logic sa, sb, sx;
        sa = a[31]; sb = b[31] ^ s;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        ma = (ea != 0) ? (longint'(1) << 23) + longint'(a[22:0]) : 64'sd0;
        mb = (eb != 0) ? (longint'(1) << 23) + longint'(b[22:0]) : 64'sd0;
        if ((ea > eb) || (ea == eb && ma >= mb)) begin
            ex = ea; mx = ma; sx = sa; en = eb; mn = mb;
        end else begin
            ex = eb; mx = mb; sx = sb; en = ea; mn = ma;
        end
        d = ex - en;
        mn = (d > 24) ? 64'sd0 : (mn >>> d);
        sm = (sa == sb) ? mx + mn : mx - mn;
        e = ex; nsh = 0;
        if (sm == 0) begin
            res = 32'h0; flg = 4'b0100;
        end else if (sm >= (longint'(1) << 24)) begin
            e = e + 1; sm = sm >>> 1;
            if (e >= 255) begin
                res = {sx, 8'hFF, 23'h0}; flg = {sx, 1'b0, 1'b1, 1'b1};
            end else begin
                res = {sx, 8'(e), sm[22:0]}; flg = {sx, 1'b0, 1'b1, 1'b0};
            end
        end else begin
            while (sm < (longint'(1) << 23) && e > 0) begin
                sm = sm <<< 1; e = e - 1; nsh = nsh + 1;
            end
            if (e == 0) begin
                res = {sx, 31'h0}; flg = {sx, 1'b1, 1'b0, 1'b0};
            end else begin
                res = {sx, 8'(e), sm[22:0]}; flg = {sx, 1'b0, 1'b0, 1'b0};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = 8'($urandom_range(1, 254));
        if ($urandom_range(0, 15) == 0) e = 8'h00;
        if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(1, 12));
        return {1'($urandom_range(0, 1)), e, 23'($urandom_range(0, 32'h7FFFFF))};
    endfunction

    // Drive one operation; latency counted with the cycle after accept as 1.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit release_it, output logic [31:0] r, output logic [3:0] f,
                          output int lat, output bit to);
        @(negedge clk);
        srcA = a; srcB = b; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; lat = 1; to = 1'b0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) to = 1'b1;
        r = result; f = ALUFlags;
        if (release_it) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, result, ALUFlags} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%b vld=%b res=%h flg=%b want 1 0 0 0",
                     in_ready, out_valid, result, ALUFlags);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [7], vb [7], er [7], r;
        logic        vs [7];
        logic [3:0]  ef [7], f;
        int          el [7], lat;
        bit          to;
        va = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h4B800000, 32'h7F7FFFFF, 32'h82800000};
        vb = '{32'h3F800000, 32'h3E800000, 32'h3F800000, 32'h3F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 32'h827FFFFF};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        er = '{32'h40000000, 32'h3FE00000, 32'h00000000, 32'h34000000, 32'h4B800000, 32'h7F800000, 32'h80000000};
        ef = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0011, 4'b1100};
        el = '{4, 4, 4, 27, 4, 4, 9};
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], vs[i], 1'b1, r, f, lat, to);
            checks++;
            if (to || r !== er[i] || f !== ef[i] || lat != el[i]) begin
                failures++;
                $display("FAIL directed_%0d got res=%h flg=%b lat=%0d to=%0d want res=%h flg=%b lat=%0d",
                         i, r, f, lat, to, er[i], ef[i], el[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, er;
        logic [3:0]  f, ef;
        logic        s;
        int          lat, nsh;
        bit          to;
        for (int i = 0; i < 60; i++) begin
            a = rnd_fp();
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0 && a[30:23] > 8'd1 && a[30:23] < 8'd254)
                b = {1'($urandom_range(0, 1)), a[30:0] - 31'($urandom_range(0, 3))};
            else
                b = rnd_fp();
            ref_add(a, b, s, er, ef, nsh);
            run_op(a, b, s, 1'b1, r, f, lat, to);
            checks++;
            if (to || r !== er || f !== ef || lat != 4 + nsh) begin
                failures++;
                $display("FAIL random_%0d a=%h b=%h sub=%b got res=%h flg=%b lat=%0d want res=%h flg=%b lat=%0d",
                         i, a, b, s, r, f, lat, er, ef, 4 + nsh);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, r2;
        logic [3:0]  f, f2;
        int          lat, stray;
        bit          to;
        run_op(32'h3FC00000, 32'h3E800000, 1'b0, 1'b0, r, f, lat, to);
        checks++;
        if (to || r !== 32'h3FE00000) begin
            failures++;
            $display("FAIL bp_result got %h to=%0d want 3fe00000", r, to);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            srcA = 32'h40400000; srcB = 32'h40400000; sub = 1'b0;
            in_valid = (i % 2 == 0);
            checks++;
            if (result !== r || ALUFlags !== f || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold_%0d got res=%h flg=%b rdy=%b vld=%b want res=%h flg=%b rdy=0 vld=1",
                         i, result, ALUFlags, in_ready, out_valid, r, f);
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== r) begin
            failures++;
            $display("FAIL bp_release got vld=%b rdy=%b res=%h want 0 1 %h", out_valid, in_ready, result, r);
        end
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL bp_no_capture got %0d valid cycles want 0", stray);
        end
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, r2, f2, lat, to);
        checks++;
        if (to || r2 !== 32'h40000000 || f2 !== 4'b0010) begin
            failures++;
            $display("FAIL bp_next got res=%h flg=%b want 40000000 0010", r2, f2);
        end
    endtask

    task automatic test_back_to_back();
        int acc, done;
        acc = 0; done = 0;
        @(negedge clk);
        srcA = 32'h3FC00000; srcB = 32'h3E800000; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (in_ready) acc++;
            if (out_valid) begin
                done++;
                checks++;
                if (result !== 32'h3FE00000 || ALUFlags !== 4'b0000) begin
                    failures++;
                    $display("FAIL b2b_result got res=%h flg=%b want 3fe00000 0000", result, ALUFlags);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (acc != 5 || done != 5) begin
            failures++;
            $display("FAIL b2b_throughput got acc=%0d done=%0d want 5 5", acc, done);
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset_midop();
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        bit          to;
        @(negedge clk);
        srcA = 32'h3F800000; srcB = 32'h3F7FFFFF; sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, result, ALUFlags} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            failures++;
            $display("FAIL midop_reset got rdy=%b vld=%b res=%h flg=%b want 1 0 0 0",
                     in_ready, out_valid, result, ALUFlags);
        end
        @(negedge clk); reset = 1'b1;
        run_op(32'h3F800000, 32'h3F7FFFFF, 1'b1, 1'b1, r, f, lat, to);
        checks++;
        if (to || r !== 32'h34000000 || f !== 4'b0000 || lat != 27) begin
            failures++;
            $display("FAIL midop_after got res=%h flg=%b lat=%0d want 34000000 0000 27", r, f, lat);
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        srcA = 32'h0; srcB = 32'h0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
